// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: derives byte enables, replicates store data,
// runs a req/ack bus handshake with timeout and registers load data for the extension stage.
module mem_access_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        MemWrite,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  BE,
  output logic [31:0] rdata_q,
  output logic        rdata_valid,
  output logic        stall,
  output logic        misalign,
  output logic        bus_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_ERR} state_t;

  state_t            state_q, state_d;
  logic [TO_W-1:0]   cnt_q;
  logic [31:0]       addr_q, wdata_q;
  logic [3:0]        be_q;
  logic              we_q;
  logic              cause_to_q;

  logic [3:0]        be_calc;
  logic              mis_calc;
  logic [31:0]       wdata_rep;
  logic              timeout_hit;

  // NOTE: every signal written in an always_comb gets a default first, otherwise a
  // path that skips the assignment infers a latch.
  always_comb begin
    be_calc   = 4'b0000;
    mis_calc  = 1'b0;
    wdata_rep = wdata;
    unique case (size)
      2'b00: begin
        be_calc   = 4'b0001 << addr[1:0];
        wdata_rep = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_calc   = addr[1] ? 4'b1100 : 4'b0011;
        mis_calc  = addr[0];
        wdata_rep = {2{wdata[15:0]}};
      end
      2'b10: begin
        be_calc  = 4'b1111;
        mis_calc = |addr[1:0];
      end
      default: mis_calc = 1'b1;
    endcase
  end

  assign timeout_hit = (cnt_q == TO_W'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // Gated with rst_n so the pipeline is released the moment reset is asserted.
        stall = req_valid & rst_n;
        if (req_valid) state_d = mis_calc ? S_ERR : S_REQ;
      end
      S_REQ: begin
        stall = 1'b1;
        if (bus_ack)          state_d = S_DONE;
        else if (timeout_hit) state_d = S_ERR;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      we_q       <= 1'b0;
      cause_to_q <= 1'b0;
      rdata_q    <= '0;
      BE         <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            cause_to_q <= 1'b0;
            if (!mis_calc) begin
              addr_q  <= {addr[31:2], 2'b00};
              be_q    <= be_calc;
              we_q    <= MemWrite;
              wdata_q <= wdata_rep;
              cnt_q   <= '0;
            end
          end
        end
        S_REQ: begin
          cnt_q <= cnt_q + 1'b1;
          if (bus_ack) begin
            if (!we_q) begin
              rdata_q <= bus_rdata;
              BE      <= be_q;
            end
          end else if (timeout_hit) begin
            cause_to_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus_req     = (state_q == S_REQ);
  assign bus_we      = we_q;
  assign bus_addr    = addr_q;
  assign bus_be      = be_q;
  assign bus_wdata   = wdata_q;
  assign rdata_valid = (state_q == S_DONE) & ~we_q;
  assign misalign    = (state_q == S_ERR) & ~cause_to_q;
  assign bus_err     = (state_q == S_ERR) & cause_to_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: stimulus queues expected bus and completion
// records, a monitor compares them when the DUT raises bus_req or ends a stall.
module tb_mem_access_ctrl;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    int          len;
  } bus_exp_t;

  typedef struct {
    logic        rv;
    logic        mis;
    logic        berr;
    logic [3:0]  be;
    logic [31:0] rd;
    int          stall_len;
  } resp_exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        MemWrite = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic [3:0]  BE;
  logic [31:0] rdata_q;
  logic        rdata_valid, stall, misalign, bus_err;

  int n_checks = 0;
  int n_errors = 0;

  bus_exp_t  bus_q[$];
  resp_exp_t resp_q[$];

  int          wait_n = 0;
  logic [31:0] rd_val = '0;
  logic        stray_ack = 1'b0;

  mem_access_ctrl #(.TIMEOUT(16), .TO_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .MemWrite(MemWrite),
    .size(size), .addr(addr), .wdata(wdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .BE(BE), .rdata_q(rdata_q), .rdata_valid(rdata_valid), .stall(stall),
    .misalign(misalign), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Bus slave: acks after wait_n wait states; never acks if wait_n exceeds the timeout.
  initial begin
    int wcnt = 0;
    forever begin
      @(posedge clk);
      #2;
      if (bus_req) begin
        bus_ack   = (wcnt == wait_n) || stray_ack;
        bus_rdata = rd_val;
        wcnt++;
      end else begin
        bus_ack   = stray_ack;
        bus_rdata = rd_val;
        wcnt      = 0;
      end
    end
  end

  // Monitor: pops a bus record on each bus_req rise and a completion record when stall ends.
  initial begin
    bus_exp_t  cur;
    resp_exp_t r;
    logic      prev_req = 1'b0;
    int        req_run = 0;
    int        stall_run = 0;
    cur = '{32'h0, 4'h0, 1'b0, 32'h0, 0};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_req  = 1'b0;
        req_run   = 0;
        stall_run = 0;
      end else begin
        if (bus_req) begin
          if (!prev_req) begin
            if (bus_q.size() == 0) begin
              check("bus_unexpected", 32'(bus_req), 32'h0);
            end else begin
              cur = bus_q.pop_front();
              check("bus_addr", bus_addr, cur.addr);
              check("bus_be", 32'(bus_be), 32'(cur.be));
              check("bus_we", 32'(bus_we), 32'(cur.we));
              check("bus_wdata", bus_wdata, cur.wdata);
            end
            req_run = 1;
          end else begin
            check("bus_addr_stable", bus_addr, cur.addr);
            check("bus_be_stable", 32'(bus_be), 32'(cur.be));
            check("bus_we_stable", 32'(bus_we), 32'(cur.we));
            check("bus_wdata_stable", bus_wdata, cur.wdata);
            req_run++;
          end
        end else if (prev_req) begin
          check("bus_req_len", 32'(req_run), 32'(cur.len));
        end
        prev_req = bus_req;

        if (stall) begin
          stall_run++;
        end else if (stall_run > 0) begin
          if (resp_q.size() == 0) begin
            check("resp_unexpected", 32'(stall_run), 32'h0);
          end else begin
            r = resp_q.pop_front();
            check("rdata_valid", 32'(rdata_valid), 32'(r.rv));
            check("misalign", 32'(misalign), 32'(r.mis));
            check("bus_err", 32'(bus_err), 32'(r.berr));
            check("BE", 32'(BE), 32'(r.be));
            check("rdata_q", rdata_q, r.rd);
            check("stall_len", 32'(stall_run), 32'(r.stall_len));
          end
          stall_run = 0;
        end else begin
          check("no_pulse", 32'({rdata_valid, misalign, bus_err}), 32'h0);
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input int waits, input logic [31:0] rd,
                       input bit has_bus, input bus_exp_t b, input resp_exp_t r);
    bit done = 1'b0;
    if (has_bus) bus_q.push_back(b);
    resp_q.push_back(r);
    wait_n    = waits;
    rd_val    = rd;
    req_valid = 1'b1;
    MemWrite  = we;
    size      = sz;
    addr      = a;
    wdata     = wd;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (!stall) done = 1'b1;
    end
    if (!done) check("issue_bound", 32'h0, 32'h1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  initial begin
    #1;
    check("rst_bus_req", 32'(bus_req), 32'h0);
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_BE", 32'(BE), 32'h0);
    check("rst_rdata_q", rdata_q, 32'h0);
    check("rst_bus_addr", bus_addr, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Load byte, zero wait.
    issue(1'b0, 2'b00, 32'h0000_1003, 32'h0, 0, 32'hAABB_CCDD, 1'b1,
          '{32'h0000_1000, 4'b1000, 1'b0, 32'h0, 1},
          '{1'b1, 1'b0, 1'b0, 4'b1000, 32'hAABB_CCDD, 2});
    // Store half, three wait states.
    issue(1'b1, 2'b01, 32'h0000_2002, 32'h0000_1234, 3, 32'hDEAD_BEEF, 1'b1,
          '{32'h0000_2000, 4'b1100, 1'b1, 32'h1234_1234, 4},
          '{1'b0, 1'b0, 1'b0, 4'b1000, 32'hAABB_CCDD, 5});
    // Misaligned word, half, and illegal size.
    issue(1'b0, 2'b10, 32'h0000_3001, 32'h0, 0, 32'h0, 1'b0,
          '{32'h0, 4'h0, 1'b0, 32'h0, 0},
          '{1'b0, 1'b1, 1'b0, 4'b1000, 32'hAABB_CCDD, 1});
    issue(1'b0, 2'b01, 32'h0000_3003, 32'h0, 0, 32'h0, 1'b0,
          '{32'h0, 4'h0, 1'b0, 32'h0, 0},
          '{1'b0, 1'b1, 1'b0, 4'b1000, 32'hAABB_CCDD, 1});
    issue(1'b0, 2'b11, 32'h0000_3000, 32'h0, 0, 32'h0, 1'b0,
          '{32'h0, 4'h0, 1'b0, 32'h0, 0},
          '{1'b0, 1'b1, 1'b0, 4'b1000, 32'hAABB_CCDD, 1});
    // Timeout: no ack.
    issue(1'b0, 2'b10, 32'h0000_5000, 32'h0, 100, 32'h0, 1'b1,
          '{32'h0000_5000, 4'b1111, 1'b0, 32'h0, 16},
          '{1'b0, 1'b0, 1'b1, 4'b1000, 32'hAABB_CCDD, 17});
    // Ack on the 16th REQ cycle completes normally.
    issue(1'b0, 2'b10, 32'h0000_5004, 32'h0, 15, 32'h1234_5678, 1'b1,
          '{32'h0000_5004, 4'b1111, 1'b0, 32'h0, 16},
          '{1'b1, 1'b0, 1'b0, 4'b1111, 32'h1234_5678, 17});
    // Store byte replication, one wait state.
    issue(1'b1, 2'b00, 32'h0000_6003, 32'h0000_00AB, 1, 32'h0, 1'b1,
          '{32'h0000_6000, 4'b1000, 1'b1, 32'hABAB_ABAB, 2},
          '{1'b0, 1'b0, 1'b0, 4'b1111, 32'h1234_5678, 3});
    // Back-to-back store word then load byte.
    issue(1'b1, 2'b10, 32'h0000_4000, 32'hCAFE_F00D, 0, 32'h0, 1'b1,
          '{32'h0000_4000, 4'b1111, 1'b1, 32'hCAFE_F00D, 1},
          '{1'b0, 1'b0, 1'b0, 4'b1111, 32'h1234_5678, 2});
    issue(1'b0, 2'b00, 32'h0000_4001, 32'h0, 0, 32'h0000_5500, 1'b1,
          '{32'h0000_4000, 4'b0010, 1'b0, 32'h0, 1},
          '{1'b1, 1'b0, 1'b0, 4'b0010, 32'h0000_5500, 2});

    // Asynchronous reset during a REQ wait state.
    bus_q.push_back('{32'h0000_7000, 4'b1111, 1'b0, 32'h0, 0});
    wait_n    = 100;
    req_valid = 1'b1;
    MemWrite  = 1'b0;
    size      = 2'b10;
    addr      = 32'h0000_7000;
    wdata     = 32'h0;
    repeat (3) @(negedge clk);
    check("pre_rst_bus_req", 32'(bus_req), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_bus_req", 32'(bus_req), 32'h0);
    check("arst_stall", 32'(stall), 32'h0);
    check("arst_bus_addr", bus_addr, 32'h0);
    check("arst_bus_be", 32'(bus_be), 32'h0);
    check("arst_BE", 32'(BE), 32'h0);
    check("arst_rdata_q", rdata_q, 32'h0);
    check("arst_pulses", 32'({rdata_valid, misalign, bus_err}), 32'h0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    stray_ack = 1'b1;
    rd_val    = 32'hFFFF_FFFF;
    repeat (2) begin
      @(negedge clk);
      check("post_rst_bus_req", 32'(bus_req), 32'h0);
      check("post_rst_rdata_q", rdata_q, 32'h0);
      check("post_rst_BE", 32'(BE), 32'h0);
    end
    @(posedge clk);
    #1;
    stray_ack = 1'b0;
    @(posedge clk);
    #1;

    // Recovery after reset.
    issue(1'b0, 2'b00, 32'h0000_8002, 32'h0, 0, 32'h00CC_0000, 1'b1,
          '{32'h0000_8000, 4'b0100, 1'b0, 32'h0, 1},
          '{1'b1, 1'b0, 1'b0, 4'b0100, 32'h00CC_0000, 2});

    repeat (3) @(negedge clk);
    check("bus_q_empty", 32'(bus_q.size()), 32'h0);
    check("resp_q_empty", 32'(resp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Data-memory access controller in the MEM stage, directly upstream of the load byte-extension stage.
- Accepts one load/store request per instruction and derives the byte-enable BE[3:0] from address and access size.
- Lane-replicates store data, runs a req/ack handshake with the data bus (with wait states and timeout), and registers read data plus BE for the extension stage.
- Stalls the pipeline while the bus transaction is outstanding.

Parameters:
TIMEOUT, 16, max cycles in REQ without bus_ack before abort (>=2)
TO_W, 5, width of timeout counter (must hold TIMEOUT)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  MEM-stage load/store present
MemWrite  in  1  1=store, 0=load
size  in  2  00 byte, 01 half, 10 word, 11 illegal
addr  in  32  byte address
wdata  in  32  store data, right-justified
bus_req  out  1  bus request, held until ack
bus_we  out  1  bus write
bus_addr  out  32  word-aligned address {addr[31:2],2'b00}
bus_be  out  4  bus byte lanes
bus_wdata  out  32  lane-replicated store data
bus_ack  in  1  bus completion, one-cycle pulse
bus_rdata  in  32  read data, valid with bus_ack
BE  out  4  registered BE for extension stage
rdata_q  out  32  registered raw read word for extension stage
rdata_valid  out  1  rdata_q/BE valid (load DONE cycle)
stall  out  1  freeze PC/IF/ID/EX/MEM registers
misalign  out  1  one-cycle address-error pulse
bus_err  out  1  one-cycle timeout pulse

Behaviour:
- Reset: all outputs and registers 0, state IDLE; async assertion drops bus_req immediately, mid-transaction included; the in-flight access is abandoned, no done/err pulse.
- BE derivation:
  - word: 1111, requires addr[1:0]=00.
  - half: addr[1]?1100:0011, requires addr[0]=0.
  - byte: 0001<<addr[1:0].
  - Violation or size=11 is misaligned.
- Store replication: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
- FSM IDLE/REQ/DONE/ERR:
  - IDLE:
    - req_valid & legal: latch bus_addr, bus_be, bus_we, bus_wdata; clear counter; go REQ.
    - req_valid & misaligned: go ERR, no bus_req.
    - stall = req_valid (combinational) in IDLE.
  - REQ:
    - bus_req=1; bus_addr/be/we/wdata stable until ack; stall=1; counter increments each cycle.
    - bus_ack: for loads capture rdata_q<=bus_rdata, BE<=latched be; go DONE.
    - Counter reaches TIMEOUT-1 with no ack: go ERR with bus_err cause.
    - Ack on the timeout cycle wins (completes normally).
  - DONE:
    - One cycle; stall=0; rdata_valid=1 for loads (0 for stores); go IDLE.
    - req_valid is ignored, since it is the same instruction advancing.
  - ERR:
    - One cycle; stall=0; misalign or bus_err=1 per cause; go IDLE.
    - No register write-back of rdata_q.
- Latency:
  - Zero-wait bus (ack first REQ cycle): the request occupies 3 cycles (IDLE-accept, REQ, DONE) and stall is high for 2.
  - Each extra wait state adds 1.
- rdata_q and BE hold their last values outside DONE.
  - Stores do not update them.
- bus_ack outside REQ is ignored.
- Minimum spacing between back-to-back requests is 3 cycles; no pipelining of bus requests.

Test Plan:
- Load byte, addr=0x1003, ack 1st REQ cycle, bus_rdata=0xAABBCCDD -> bus_addr=0x1000, bus_be=1000, BE=1000, rdata_q=0xAABBCCDD, rdata_valid pulse; stall high exactly 2 cycles.
- Store half, addr=0x2002, wdata=0x00001234, ack after 3 waits -> bus_we=1, bus_be=1100, bus_wdata=0x12341234, all stable 4 REQ cycles; stall high 5 cycles; rdata_valid stays 0.
- Load word, addr=0x3001 -> no bus_req, misalign one-cycle pulse, stall high 1 cycle only; load half addr=0x3003 -> same.
- Load word, no ack, TIMEOUT=16 -> bus_req high exactly 16 cycles, then bus_err pulse, return IDLE; ack arriving on 16th cycle instead -> normal DONE, no bus_err.
- rst_n low during REQ wait state -> bus_req, stall, all outputs 0 asynchronously; after release with req_valid=0, bus_req stays 0; later ack ignored.
- Back-to-back: store word 0x4000 then load byte 0x4001 (0x00005500) -> second req accepted in IDLE after DONE, BE=0010, rdata_q updated only by the load.
